// File: rtl/serial_alu_pkg.sv
// Shared types and constants for the bit-serial add/subtract datapath.
//   state_t   : controller states (IDLE, RUN, DONE)
//   DEFAULT_W : default operand width
package serial_alu_pkg;

  localparam int unsigned DEFAULT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Handshake/operand bundle between a requester and serial_subtractor.
//   start        : request, honoured only while not busy
//   a, b         : operands, captured on an accepted start
//   busy, done   : in-progress flag and one-cycle result-valid pulse
//   diff, borrow, ovf : result, held until the next accepted start
//   add          : operation select, only present with SERIAL_SUB_ADD_MODE_EN
// master drives the request side; slave is the subtractor.
interface serial_subtractor_if #(
  parameter int unsigned W = serial_alu_pkg::DEFAULT_W
) ();

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
  logic         ovf;

`ifdef SERIAL_SUB_ADD_MODE_EN
  logic         add;

  modport master (output start, a, b, add, input busy, done, diff, borrow, ovf);
  modport slave  (input start, a, b, add, output busy, done, diff, borrow, ovf);
`else
  modport master (output start, a, b, input busy, done, diff, borrow, ovf);
  modport slave  (input start, a, b, output busy, done, diff, borrow, ovf);
`endif

endinterface

// File: rtl/serial_subtractor_fa.sv
// One-bit full adder used as the bit cell of the serial datapath.
//   a, b, ci : addend bits and carry-in
//   s, co    : sum and carry-out
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor: diff = a - b, one bit per clock, LSB first, through a single
// full-adder cell computing a + ~b + 1. Result is valid from the done pulse and held until
// the next accepted start.
//   hz100  : clock
//   reset  : asynchronous, active-low
//   bus    : serial_subtractor_if.slave (start/a/b in; busy/done/diff/borrow/ovf out)
// Optional build macro SERIAL_SUB_ADD_MODE_EN adds bus.add; add=1 computes a + b, borrow then
// reports the unsigned carry-out and ovf the signed add overflow.
module serial_subtractor
  import serial_alu_pkg::*;
#(
  parameter int unsigned W = DEFAULT_W
) (
  input  logic                 hz100,
  input  logic                 reset,
  serial_subtractor_if.slave   bus
);

  localparam int unsigned CntW = $clog2(W) + 1;

  state_t          r_state;
  state_t          w_state_next;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_diff;
  logic            r_carry;
  logic            r_borrow;
  logic            r_ovf;
  logic [CntW-1:0] r_cnt;

  logic            w_accept;
  logic            w_last;
  logic            w_b_bit;
  logic            w_s;
  logic            w_co;
  logic            w_borrow_bit;
  logic            w_ovf_bit;
  logic            w_carry_init;

  assign w_accept = bus.start && (r_state != RUN);
  assign w_last   = (r_state == RUN) && (r_cnt == CntW'(W - 1));

  // On the final bit edge r_a[0]/r_b[0] hold the original operand MSBs.
`ifdef SERIAL_SUB_ADD_MODE_EN
  logic r_add;

  assign w_carry_init = ~bus.add;
  assign w_b_bit      = r_add ? r_b[0] : ~r_b[0];
  assign w_borrow_bit = r_add ? w_co : ~w_co;
  assign w_ovf_bit    = r_add ? ((r_a[0] == r_b[0]) && (w_s != r_a[0]))
                              : ((r_a[0] != r_b[0]) && (w_s != r_a[0]));
`else
  assign w_carry_init = 1'b1;
  assign w_b_bit      = ~r_b[0];
  assign w_borrow_bit = ~w_co;
  assign w_ovf_bit    = (r_a[0] != r_b[0]) && (w_s != r_a[0]);
`endif

  fa u_fa (
    .a  (r_a[0]),
    .b  (w_b_bit),
    .ci (r_carry),
    .s  (w_s),
    .co (w_co)
  );

  // State register
  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (bus.start) w_state_next = RUN;
      RUN:     if (w_last) w_state_next = DONE;
      DONE:    w_state_next = bus.start ? RUN : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.busy   = (r_state == RUN);
    bus.done   = (r_state == DONE);
    bus.diff   = r_diff;
    bus.borrow = r_borrow;
    bus.ovf    = r_ovf;
  end

  // Datapath: operand shift registers, result shift register, carry and bit counter
  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_diff   <= '0;
      r_carry  <= 1'b0;
      r_borrow <= 1'b0;
      r_ovf    <= 1'b0;
      r_cnt    <= '0;
`ifdef SERIAL_SUB_ADD_MODE_EN
      r_add    <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a      <= bus.a;
      r_b      <= bus.b;
      r_diff   <= '0;
      r_carry  <= w_carry_init;
      r_borrow <= 1'b0;
      r_ovf    <= 1'b0;
      r_cnt    <= '0;
`ifdef SERIAL_SUB_ADD_MODE_EN
      r_add    <= bus.add;
`endif
    end else if (r_state == RUN) begin
      r_a     <= {1'b0, r_a[W-1:1]};
      r_b     <= {1'b0, r_b[W-1:1]};
      r_diff  <= {w_s, r_diff[W-1:1]};
      r_carry <= w_co;
      r_cnt   <= r_cnt + CntW'(1);
      if (w_last) begin
        r_borrow <= w_borrow_bit;
        r_ovf    <= w_ovf_bit;
      end
    end
  end

endmodule
